// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating output mux.
// Mode selectors and the channel-index width function live here so the top
// and the round-robin arbiter agree on encodings.
package arb_mux_pkg;

  localparam int MODE_SEL = 0;  // channel picked by the external sel input
  localparam int MODE_RR  = 1;  // channel picked by rotating priority

  // Ceiling log2, used to size channel indices (callers pass n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requester after ptr, wrapping around.
// Purely combinational; grant and any are forced low when enable is low.
// ptr is owned by the caller, so priority only rotates on real transfers.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         enable,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  // Winner is the requester with the smallest distance past ptr (mod N).
  always_comb begin
    int best_d;
    int d;
    best_d    = N;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - int'(ptr) - 1) % N;
      if (req[i] && (d < best_d)) begin
        best_d    = d;
        grant_idx = W'(i);
      end
    end
    any   = (best_d < N) && enable;
    grant = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 mux with a one-entry registered output, channel chosen by sel or round-robin.
// One cycle from input handshake to out_valid; sustains one word per cycle.
// in_ready drops for all channels while the output word is stalled or rst is high.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_SEL,
  localparam int SELW    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q;
  logic                can_load;
  logic [CHANNELS-1:0] grant_oh;
  logic [SELW-1:0]     grant_idx;
  logic                grant_any;

  // Output slot can take a word when empty or draining this cycle; never in reset.
  assign can_load = (!out_valid_q || out_ready) && !rst;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] ptr_q, ptr_d;

      rr_arbiter #(.N(CHANNELS), .W(SELW)) u_rr (
        .req       (in_valid),
        .ptr       (ptr_q),
        .enable    (can_load),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
      );

      // Priority pointer only advances when a word is actually taken.
      always_comb ptr_d = grant_any ? grant_idx : ptr_q;

      // Reset to the last channel so channel 0 wins first.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= SELW'(CHANNELS - 1);
        else     ptr_q <= ptr_d;
      end
    end else begin : g_sel
      // Grant only the addressed channel, and only if it offers a word;
      // out-of-range sel values match no channel and never grant.
      always_comb begin
        grant_oh = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          if (sel == SELW'(i)) grant_oh[i] = in_valid[i] && can_load;
        end
      end

      assign grant_idx = sel;
      assign grant_any = |grant_oh;
    end
  endgenerate

  assign in_ready = grant_oh;

  // Pick the granted channel's word for the output register.
  always_comb begin
    out_data_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SELW'(i)) out_data_d = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output slot: load replaces (even while draining), drain alone clears valid only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (grant_any) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      out_chan_q  <= grant_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
